// File: rtl/cft_constant_store.sv
// Read-only constant slots 0..NUM_CONST-1 on the ibus; optional access counter under CONSTANT_STORE_HITCNT_EN.
// Latency: ibus/hit are combinational from nruen/raddr/reset; hit_count updates one clk edge after a new access.
// Backpressure: none; the bus is released to high-Z whenever the window is not selected or reset is high.
module cft_constant_store #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int BASE_ADDR  = 4,
    parameter int NUM_CONST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  nruen,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output tri   [DATA_WIDTH-1:0] ibus,
    output logic                  hit,
    output logic [CNT_WIDTH-1:0]  hit_count
);

    // One extra bit so BASE_ADDR+NUM_CONST can sit just past the top of the address space.
    localparam logic [ADDR_WIDTH:0]   WIN_LO   = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   WIN_HI   = (ADDR_WIDTH+1)'(BASE_ADDR + NUM_CONST);
    localparam logic [ADDR_WIDTH-1:0] BASE_OFF = ADDR_WIDTH'(BASE_ADDR);

    logic [ADDR_WIDTH:0]   raddr_ext;
    logic                  in_window;
    logic [ADDR_WIDTH-1:0] slot_idx;
    logic [DATA_WIDTH-1:0] const_dat;

    assign raddr_ext = {1'b0, raddr};
    assign in_window = (raddr_ext >= WIN_LO) && (raddr_ext < WIN_HI);
    assign hit       = !reset && !nruen && in_window;
    assign slot_idx  = raddr - BASE_OFF;
    assign const_dat = DATA_WIDTH'(slot_idx);

    // An X on hit merges const_dat with Z, so unknown inputs never produce a wrong known value.
    assign ibus = hit ? const_dat : {DATA_WIDTH{1'bz}};

`ifdef CONSTANT_STORE_HITCNT_EN
    logic                 hit_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Count rising edges of hit only: a held access, even across slots, is counted once.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            hit_q <= hit;
            if (hit && !hit_q) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign hit_count = cnt_q;
`else
    logic unused_clk;

    assign unused_clk = clk;
    assign hit_count  = '0;
`endif

endmodule

// File: tb/tb_cft_constant_store.sv
`timescale 1ns/100ps
// Directed bench for cft_constant_store: address/enable sweep table plus hand-written counter and reset sequences.
// Counter expectations collapse to zero when the block is built without CONSTANT_STORE_HITCNT_EN.
module tb_cft_constant_store;

`ifdef CONSTANT_STORE_HITCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        nruen;
    logic [4:0]  raddr;
    tri   [15:0] ibus;
    logic        hit;
    logic [15:0] hit_count;

    int vectors;
    int miscompares;

    typedef struct {
        logic        nruen;
        logic [4:0]  raddr;
        logic        exp_hit;
        logic        exp_z;
        logic [15:0] exp_dat;
    } vec_t;

    vec_t sweep [64];

    cft_constant_store dut (
        .clk       (clk),
        .reset     (reset),
        .nruen     (nruen),
        .raddr     (raddr),
        .ibus      (ibus),
        .hit       (hit),
        .hit_count (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic exp_z, input logic [15:0] exp_dat);
        logic [15:0] act;
        logic [15:0] zval;
        act  = ibus;
        zval = 16'bz;
        vectors++;
        if (exp_z ? (act !== zval) : (act !== exp_dat)) begin
            miscompares++;
            if (exp_z) $display("FAIL %s: ibus got %h, expected zzzz", name, act);
            else       $display("FAIL %s: ibus got %h, expected %h", name, act, exp_dat);
        end
    endtask

    function automatic logic [15:0] cexp(input int n);
        return CNT_EN ? 16'(n) : 16'h0000;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Sweep table: everything released except nruen=0 with raddr 4..7.
        for (int i = 0; i < 64; i++) begin
            sweep[i] = '{nruen: i[5], raddr: i[4:0], exp_hit: 1'b0, exp_z: 1'b1, exp_dat: 16'h0000};
        end
        sweep[4] = '{nruen: 1'b0, raddr: 5'd4, exp_hit: 1'b1, exp_z: 1'b0, exp_dat: 16'h0000};
        sweep[5] = '{nruen: 1'b0, raddr: 5'd5, exp_hit: 1'b1, exp_z: 1'b0, exp_dat: 16'h0001};
        sweep[6] = '{nruen: 1'b0, raddr: 5'd6, exp_hit: 1'b1, exp_z: 1'b0, exp_dat: 16'h0002};
        sweep[7] = '{nruen: 1'b0, raddr: 5'd7, exp_hit: 1'b1, exp_z: 1'b0, exp_dat: 16'h0003};

        // Reset state, including reset overriding a live window access.
        reset = 1'b1;
        nruen = 1'b1;
        raddr = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_count", hit_count, 16'h0000);
        chk("reset_hit_idle", {15'd0, hit}, 16'd0);
        nruen = 1'b0;
        raddr = 5'd6;
        #1;
        chk_bus("reset_gates_bus", 1'b1, 16'h0000);
        chk("reset_gates_hit", {15'd0, hit}, 16'd0);
        @(negedge clk);
        chk("reset_edge_count", hit_count, 16'h0000);

        nruen = 1'b1;
        raddr = 5'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 64; i++) begin
            nruen = sweep[i].nruen;
            raddr = sweep[i].raddr;
            #30;
            chk_bus($sformatf("sweep_bus_%0d", i), sweep[i].exp_z, sweep[i].exp_dat);
            chk($sformatf("sweep_hit_%0d", i), {15'd0, hit}, {15'd0, sweep[i].exp_hit});
            #33.5;
        end
        @(negedge clk);
        chk("sweep_count", hit_count, cexp(1));

        // Disabled read of a window address.
        nruen = 1'b1;
        raddr = 5'd5;
        repeat (2) @(negedge clk);
        chk_bus("disabled_bus", 1'b1, 16'h0000);
        chk("disabled_hit", {15'd0, hit}, 16'd0);
        chk("disabled_count", hit_count, cexp(1));

        // Held access across slots counts once; a one-cycle release starts a new access.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("held_start", hit_count, 16'h0000);
        nruen = 1'b0;
        raddr = 5'd4;
        repeat (10) @(negedge clk);
        chk("held_slot4", hit_count, cexp(1));
        raddr = 5'd7;
        repeat (5) @(negedge clk);
        chk_bus("held_slot7_bus", 1'b0, 16'h0003);
        chk("held_slot7", hit_count, cexp(1));
        nruen = 1'b1;
        @(negedge clk);
        nruen = 1'b0;
        @(negedge clk);
        chk("reaccess", hit_count, cexp(2));

        // Mid-operation reset: bus released at once, count cleared on the edge, recount after release.
        raddr = 5'd4;
        reset = 1'b1;
        #1;
        chk_bus("midreset_bus", 1'b1, 16'h0000);
        chk("midreset_hit", {15'd0, hit}, 16'd0);
        @(negedge clk);
        chk("midreset_count", hit_count, 16'h0000);
        reset = 1'b0;
        #1;
        chk_bus("postreset_bus", 1'b0, 16'h0000);
        @(negedge clk);
        chk("postreset_count", hit_count, cexp(1));

`ifdef CONSTANT_STORE_HITCNT_EN
        // Wrap-around from a preloaded all-ones count.
        nruen = 1'b1;
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        @(negedge clk);
        chk("wrap_preload", hit_count, 16'hFFFF);
        nruen = 1'b0;
        raddr = 5'd5;
        @(negedge clk);
        chk("wrap_count", hit_count, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cft_constant_store.md
Name: cft_constant_store

Overview:
- Read-only constant register file on the CFT processor's 16-bit internal bus (ibus).
- When the register-unit read enable nruen is asserted (low) and raddr selects one of the four constant slots, 5'b00100–5'b00111, the block drives the constants 0, 1, 2 and 3 onto ibus. Otherwise ibus is released to high-Z.
- A clocked hit counter supports performance and verification visibility.

Parameters:
- DATA_WIDTH, 16, width of ibus and of the constants.
- ADDR_WIDTH, 5, width of raddr.
- BASE_ADDR, 4, first raddr of the constant window.
- NUM_CONST, 4, number of constant slots. Slot k drives value k.
- CNT_WIDTH, 16, width of hit_count.

Ports:
- clk  input  1  system clock. All registers update on the rising edge.
- reset  input  1  synchronous, active-high reset.
- nruen  input  1  register read enable, active low.
- raddr  input  5  register read address.
- ibus  output (tristate)  16  internal data bus.
- hit  output  1  combinational decode: the block is currently driving ibus.
- hit_count  output  16  registered count of read accesses to the constant window.

Behaviour:
- Decode:
  - hit = (reset == 0) && (nruen == 0) && (BASE_ADDR <= raddr < BASE_ADDR+NUM_CONST).
  - With the defaults, hit = 1 exactly for raddr 4, 5, 6 and 7.
- Data path (purely combinational, no clock latency):
  - When hit = 1, ibus = zero-extended (raddr - BASE_ADDR) to DATA_WIDTH bits. Values: raddr 4→16'h0000, 5→16'h0001, 6→16'h0002, 7→16'h0003.
  - When hit = 0, all ibus bits are high-Z (16'bz). This covers nruen = 1 for any raddr, and nruen = 0 with raddr in 0–3 or 8–31.
- Timing:
  - Propagation from nruen/raddr to ibus must settle well within 30 ns.
  - No glitch to a wrong driven value is permitted while hit stays 1 and raddr is stable.
- Unknown inputs: if nruen or raddr is X/Z, ibus is X or Z. The block never drives a wrong known value.
- Reset:
  - While reset = 1, ibus is high-Z and hit = 0, regardless of nruen/raddr. The bus is released combinationally as soon as reset is high, not after a clock edge.
  - On a rising clk with reset = 1: hit_count ← 0 and the internal hit_q ← 0.
- Counter (clk domain):
  - hit_q registers hit each cycle.
  - hit_count increments by 1 on each rising clk where hit = 1 and hit_q = 0, i.e. once per new access, not once per cycle of a held access.
  - An address change inside the window while nruen stays low is not a new access.
- Wrap-around: hit_count wraps from 16'hFFFF to 16'h0000 with no saturation and no flag.
- Simultaneous events: reset has priority over increment in the same cycle.
- Mid-operation reset:
  - ibus releases immediately and the counter clears on the edge.
  - After reset deasserts with nruen already low in the window, the first clk edge counts one access.
- No other state. The block never writes or latches ibus data.

Optional Feature:
- Macro: CONSTANT_STORE_HITCNT_EN.
- Defined: hit_q and the hit_count register are implemented as described above.
- Undefined:
  - No counter flops are instantiated and hit_count is tied to 0.
  - clk and reset remain ports. reset still gates ibus and hit combinationally.
  - The data path is identical in both builds.

Test Plan:
- Sweep i = 0..63 with nruen = i[5], raddr = i[4:0], steps of 63.5 ns, checking 30 ns after each change:
  - i = 4..7 → ibus = 0000, 0001, 0002, 0003.
  - All other i → ibus = 16'bz.
- Hold nruen = 1 and set raddr = 5'b00101 → ibus = Z, hit = 0, hit_count unchanged.
- Set reset = 1, nruen = 0, raddr = 6 → ibus = Z, hit = 0. After one clk edge, hit_count = 0.
- With reset = 0, hold nruen = 0, raddr = 4 for 10 cycles, then raddr = 7 for 5 cycles → hit_count = 1. Raise nruen for 1 cycle, then lower it → hit_count = 2.
- Preload hit_count to 16'hFFFF by 65535 accesses (or force), then make one more access → hit_count = 16'h0000.
- Build without CONSTANT_STORE_HITCNT_EN and repeat the sweep → identical ibus results, hit_count constantly 0.
